ts_pump_scheduler: RTL and testbench
====================================

TS_PUMP_SCHEDULER -- requirements
Module: ts_pump_scheduler

Interface
REQ-001 The block SHALL have these parameters: C_S_AXI_DATA_WIDTH, default 32, data word width; FILTER_NUM, default 64, number of filter slots; PACK_WORD_SIZE, default 47, words per captured TS packet; SLOT_BITS, default 6, width of a slot number (ceil(log2(FILTER_NUM)), at least 1).
REQ-002 The block SHALL have these ports, clock and reset first (name, direction, width, meaning):
- S_AXI_ACLK  in  1  single clock; every register is on its rising edge.
- S_AXI_ARESETN  in  1  reset; asynchronous assert, active-low.
- sched_enable  in  1  when high, the block may start new grants.
- run_enable  in  FILTER_NUM  per-slot enable mask.
- ready_for_read  in  FILTER_NUM  per-slot level: "packet captured".
- in_data  in  FILTER_NUM*C_S_AXI_DATA_WIDTH  flattened per-slot out_data; slot s occupies bits [s*W +: W].
- in_data_index  in  FILTER_NUM*C_S_AXI_DATA_WIDTH  flattened per-slot word index, same packing.
- host_release  in  1  one-cycle pulse; the host has consumed the buffer.
- pump_enable  out  FILTER_NUM  one-hot word-pump strobe to the granted slot.
- buf_wren  out  1  write strobe to the shared packet buffer.
- buf_addr  out  8  buffer word address.
- buf_wdata  out  C_S_AXI_DATA_WIDTH  buffer write data.
- pkt_done  out  1  one-cycle pulse; a packet has been copied.
- pkt_abort  out  1  one-cycle pulse; a copy was abandoned.
- done_slot  out  SLOT_BITS  slot of the last completed or aborted copy.
- buf_busy  out  1  buffer holds an unreleased packet.

Function
REQ-003 Eligible slots SHALL be those with ready_for_read[s] & run_enable[s] both high.
REQ-004 The state machine SHALL have four states: IDLE, COPY, FLUSH, HOLD.
REQ-005 In IDLE, with sched_enable=1, buf_busy=0 and at least one eligible slot, the block SHALL grant one slot and enter COPY on the next edge.
REQ-006 Slot selection SHALL be round-robin: search from (last_grant+1) mod FILTER_NUM upward, wrapping at FILTER_NUM; last_grant resets to FILTER_NUM-1, so slot 0 wins first.
REQ-007 In COPY, pump_enable[g] SHALL be high for exactly PACK_WORD_SIZE consecutive cycles, and all other pump_enable bits SHALL stay low.
REQ-008 Filter latency is one cycle: data and index for pump k are sampled the cycle after pump k.
REQ-009 For each sample, buf_wren SHALL be 1, buf_addr SHALL be in_data_index[g] truncated to its low 8 bits, and buf_wdata SHALL be in_data[g], all registered.
REQ-010 Consequently buf_wren SHALL be asserted PACK_WORD_SIZE cycles, lagging pump_enable by one cycle; FLUSH covers the final write.
REQ-011 After the last write, pkt_done SHALL pulse for one cycle, done_slot SHALL be g, buf_busy SHALL become 1, and the state SHALL become HOLD.
REQ-012 In HOLD, no pump_enable bit SHALL be asserted; host_release SHALL clear buf_busy and return the state to IDLE on the next edge.
REQ-013 host_release outside HOLD SHALL be ignored.
REQ-014 If ready_for_read[g] or run_enable[g] drops during COPY, the block SHALL:
- deassert pump_enable on the next cycle;
- complete at most the one write already in flight;
- pulse pkt_abort for one cycle with done_slot=g;
- leave buf_busy at 0 and return to IDLE;
- advance last_grant to g.
REQ-015 Clearing sched_enable during COPY, FLUSH or HOLD SHALL NOT affect the copy in progress; it only blocks new grants from IDLE.
REQ-016 pkt_done and pkt_abort SHALL never be high in the same cycle.
REQ-017 A slot SHALL never be granted twice in a row while another slot is eligible.

Reset
REQ-018 Asserting S_AXI_ARESETN low SHALL immediately (asynchronously) force:
- state to IDLE;
- pump_enable, buf_wren, buf_addr, buf_wdata, pkt_done, pkt_abort, done_slot, buf_busy to 0;
- last_grant to FILTER_NUM-1.
REQ-019 A reset asserted mid-COPY SHALL abandon the copy with no pkt_done or pkt_abort pulse.
REQ-020 After reset release, the first grant SHALL occur no earlier than the second rising edge.

Verification
REQ-021 Single copy: slot 5 eligible; in_data_index[5] = 0..46; in_data[5] = 0xA5000000+index -> 47 pump_enable[5] cycles, 47 writes at addr 0..46 with matching data, pkt_done with done_slot=5, buf_busy=1.
REQ-022 Round-robin: slots 0, 3 and 63 held eligible; host_release 2 cycles after each pkt_done -> grant order 0, 3, 63, 0.
REQ-023 Buffer hold: slots 1 and 2 eligible; host_release withheld for 200 cycles -> no second pump; release -> slot 2 is granted.
REQ-024 Abort: ready_for_read[7] dropped after the 10th pump -> at most 11 writes, pkt_abort with done_slot=7, buf_busy=0, the next grant skips slot 7 if others are eligible.
REQ-025 Mask and enable: slot 4 ready with run_enable[4]=0 -> never granted; sched_enable=0 with slot 6 eligible -> no grant until sched_enable returns to 1.
REQ-026 Reset mid-copy: S_AXI_ARESETN pulled low at pump 20 -> all outputs 0 in the same cycle; after release, slot 0 is granted first.

Source files
------------

// File: rtl/ts_pump_scheduler.sv
// ts_pump_scheduler: round-robin copier of one captured TS packet at a time from per-slot filters into a shared buffer
//   S_AXI_ACLK/S_AXI_ARESETN : clock, async active-low reset
//   sched_enable             : permits new grants from IDLE
//   run_enable/ready_for_read: per-slot mask and "packet captured" level
//   in_data/in_data_index    : flattened per-slot filter word and its index
//   host_release             : host has consumed the buffer (honoured in HOLD only)
//   pump_enable              : one-hot word strobe to the granted slot
//   buf_wren/buf_addr/buf_wdata : shared buffer write port
//   pkt_done/pkt_abort/done_slot : completion pulses and the slot they refer to
//   buf_busy                 : buffer holds an unreleased packet
module ts_pump_scheduler #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int FILTER_NUM = 64,
  parameter int PACK_WORD_SIZE = 47,
  parameter int SLOT_BITS = 6
) (
  input  logic                                       S_AXI_ACLK,
  input  logic                                       S_AXI_ARESETN,
  input  logic                                       sched_enable,
  input  logic [FILTER_NUM-1:0]                      run_enable,
  input  logic [FILTER_NUM-1:0]                      ready_for_read,
  input  logic [FILTER_NUM*C_S_AXI_DATA_WIDTH-1:0]   in_data,
  input  logic [FILTER_NUM*C_S_AXI_DATA_WIDTH-1:0]   in_data_index,
  input  logic                                       host_release,
  output logic [FILTER_NUM-1:0]                      pump_enable,
  output logic                                       buf_wren,
  output logic [7:0]                                 buf_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]              buf_wdata,
  output logic                                       pkt_done,
  output logic                                       pkt_abort,
  output logic [SLOT_BITS-1:0]                       done_slot,
  output logic                                       buf_busy
);
  localparam int W = C_S_AXI_DATA_WIDTH;
  localparam int CW = $clog2(PACK_WORD_SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(PACK_WORD_SIZE - 1);
  typedef enum logic [1:0] {IDLE, COPY, FLUSH, HOLD} state_t;
  state_t state, state_nx;
  logic [FILTER_NUM-1:0] eligible, pump_nx;
  logic [SLOT_BITS-1:0] grant, last_grant, sel, cand;
  logic [CW-1:0] cnt;
  logic [W-1:0] cur_data;
  logic [7:0] cur_addr;
  logic armed, found, go, grant_ok, last_pump, wren_nx, abort, done_nx;
  assign eligible = ready_for_read & run_enable;
  assign grant_ok = eligible[grant];
  assign cur_data = W'(in_data >> (grant * W));
  assign cur_addr = 8'(in_data_index >> (grant * W));
  assign last_pump = cnt == LAST;
  // armed delays the first grant to the second edge after reset release
  assign go = state == IDLE && sched_enable && !buf_busy && armed && found;
  // Scan offsets from the far end down so the nearest eligible slot after
  // last_grant wins; offset FILTER_NUM is last_grant itself, chosen only when alone.
  always_comb begin
    sel = last_grant;
    found = 1'b0;
    cand = '0;
    for (int i = FILTER_NUM; i >= 1; i--) begin
      cand = SLOT_BITS'((int'(last_grant) + i) % FILTER_NUM);
      if (eligible[cand]) begin
        sel = cand;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (go ? COPY : IDLE) :
               state == COPY  ? (!grant_ok ? IDLE : last_pump ? FLUSH : COPY) :
               state == FLUSH ? HOLD :
                                (host_release ? IDLE : HOLD);
  end
  // The pump issued in the cycle eligibility drops is not written: only the
  // write already registered completes.
  always_comb begin
    abort = state == COPY && !grant_ok;
    done_nx = state == FLUSH;
    wren_nx = state == COPY && grant_ok;
    pump_nx = (go || (wren_nx && !last_pump)) ? FILTER_NUM'(1) << (go ? sel : grant) : '0;
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      pump_enable <= '0;
      buf_wren <= 1'b0;
      buf_addr <= '0;
      buf_wdata <= '0;
      pkt_done <= 1'b0;
      pkt_abort <= 1'b0;
      done_slot <= '0;
      buf_busy <= 1'b0;
      grant <= '0;
      last_grant <= SLOT_BITS'(FILTER_NUM - 1);
      cnt <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      pump_enable <= pump_nx;
      buf_wren <= wren_nx;
      if (wren_nx) begin
        buf_addr <= cur_addr;
        buf_wdata <= cur_data;
      end
      pkt_done <= done_nx;
      pkt_abort <= abort;
      if (done_nx || abort) done_slot <= grant;
      if (done_nx) buf_busy <= 1'b1;
      else if (state == HOLD && host_release) buf_busy <= 1'b0;
      if (go) begin
        grant <= sel;
        last_grant <= sel;
        cnt <= '0;
      end else if (state == COPY) cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_ts_pump_scheduler.sv
// tb_ts_pump_scheduler: randomized and directed checks of ts_pump_scheduler against a filter model and round-robin reference
module tb_ts_pump_scheduler;
  localparam int N = 64;
  localparam int W = 32;
  localparam int P = 47;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sched_enable = 1'b0;
  logic host_release = 1'b0;
  logic [N-1:0] run_enable = '0;
  logic [N-1:0] ready_for_read = '0;
  logic [N*W-1:0] in_data, in_data_index;
  logic [N-1:0] pump_enable;
  logic buf_wren;
  logic [7:0] buf_addr;
  logic [W-1:0] buf_wdata;
  logic pkt_done, pkt_abort;
  logic [5:0] done_slot;
  logic buf_busy;
  logic [W-1:0] fidx [N];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grants[$], grant_cyc[$], runs[$], dones[$], done_cyc[$], aborts[$], wr_cyc[$];
  logic [7:0] wr_addr[$];
  logic [W-1:0] wr_data[$];
  logic [N-1:0] prev_pump = '0;
  int run_len = 0;
  bit bad_onehot = 0;
  bit bad_both = 0;
  int rr_last = N - 1;

  always #5 clk = ~clk;

  ts_pump_scheduler dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .sched_enable(sched_enable),
    .run_enable(run_enable),
    .ready_for_read(ready_for_read),
    .in_data(in_data),
    .in_data_index(in_data_index),
    .host_release(host_release),
    .pump_enable(pump_enable),
    .buf_wren(buf_wren),
    .buf_addr(buf_addr),
    .buf_wdata(buf_wdata),
    .pkt_done(pkt_done),
    .pkt_abort(pkt_abort),
    .done_slot(done_slot),
    .buf_busy(buf_busy)
  );

  function automatic logic [W-1:0] base(int s);
    return 32'hA000_0000 + (W'(s) << 24);
  endfunction

  // Filter: shows its current word; each pump advances it; a finished or abandoned copy rewinds it.
  always_comb
    for (int s = 0; s < N; s++) begin
      in_data_index[s*W +: W] = fidx[s];
      in_data[s*W +: W] = base(s) + fidx[s];
    end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) for (int s = 0; s < N; s++) fidx[s] <= '0;
    else
      for (int s = 0; s < N; s++)
        if (pump_enable[s]) fidx[s] <= fidx[s] + 1;
        else if ((pkt_done || pkt_abort) && int'(done_slot) == s) fidx[s] <= '0;

  function automatic int rr_next(logic [N-1:0] m, int last);
    for (int i = 1; i <= N; i++) if (m[6'((last + i) % N)]) return (last + i) % N;
    return -1;
  endfunction

  task automatic tick();
    int g;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      prev_pump = '0;
      return;
    end
    if ($countones(pump_enable) > 1) bad_onehot = 1;
    if (pump_enable != 0 && prev_pump == 0) begin
      g = 0;
      for (int s = 0; s < N; s++) if (pump_enable[s]) g = s;
      grants.push_back(g);
      grant_cyc.push_back(cyc);
      run_len = 0;
    end
    if (pump_enable != 0) run_len++;
    if (pump_enable == 0 && prev_pump != 0) runs.push_back(run_len);
    if (buf_wren) begin
      wr_addr.push_back(buf_addr);
      wr_data.push_back(buf_wdata);
      wr_cyc.push_back(cyc);
    end
    if (pkt_done) begin
      dones.push_back(int'(done_slot));
      done_cyc.push_back(cyc);
    end
    if (pkt_abort) aborts.push_back(int'(done_slot));
    if (pkt_done && pkt_abort) bad_both = 1;
    prev_pump = pump_enable;
  endtask

  task automatic clear_logs();
    grants.delete(); grant_cyc.delete(); runs.delete(); dones.delete(); done_cyc.delete();
    aborts.delete(); wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
  endtask

  task automatic do_reset();
    sched_enable = 0;
    host_release = 0;
    run_enable = '0;
    ready_for_read = '0;
    rst_n = 0;
    repeat (2) tick();
    clear_logs();
    rst_n = 1;
  endtask

  task automatic test_reset();
    sched_enable = 1;
    ready_for_read[0] = 1;
    run_enable[0] = 1;
    rst_n = 0;
    #1;
    checks++;
    if ({pump_enable, buf_wren, buf_addr, buf_wdata, pkt_done, pkt_abort, done_slot, buf_busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {pump_enable, buf_wren, buf_addr, buf_wdata, pkt_done, pkt_abort, done_slot, buf_busy});
    end
    repeat (3) tick();
    checks++;
    if (pump_enable !== '0) begin
      errors++;
      $display("FAIL reset_hold_pump: got %h expected 0", pump_enable);
    end
    clear_logs();
    rst_n = 1;
    tick();
    checks++;
    if (pump_enable !== '0) begin
      errors++;
      $display("FAIL reset_first_edge: pump got %h expected 0", pump_enable);
    end
    tick();
    checks++;
    if (pump_enable !== 64'd1) begin
      errors++;
      $display("FAIL reset_second_edge: pump got %h expected 1", pump_enable);
    end
  endtask

  task automatic test_single_copy();
    int bad;
    do_reset();
    ready_for_read[5] = 1;
    run_enable[5] = 1;
    sched_enable = 1;
    for (int i = 0; i < 120 && dones.size() < 1; i++) tick();
    checks++;
    if (dones.size() != 1 || dones[0] != 5) begin
      errors++;
      $display("FAIL single_done: count %0d slot %0d expected 1 x slot 5", dones.size(), dones.size() ? dones[0] : -1);
    end
    checks++;
    if (buf_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b expected 1", buf_busy);
    end
    checks++;
    if (grants.size() != 1 || grants[0] != 5 || runs.size() != 1 || runs[0] != P) begin
      errors++;
      $display("FAIL single_pumps: grants %0d runs %0d len %0d expected 1 grant of slot 5 for %0d cycles",
               grants.size(), runs.size(), runs.size() ? runs[0] : -1, P);
    end
    checks++;
    if (wr_addr.size() != P) begin
      errors++;
      $display("FAIL single_wr_count: got %0d expected %0d", wr_addr.size(), P);
    end
    bad = 0;
    for (int k = 0; k < wr_addr.size() && k < P; k++)
      if (wr_addr[k] !== 8'(k) || wr_data[k] !== 32'hA500_0000 + W'(k)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_wr_content: %0d bad writes, first addr %h data %h expected 00 a5000000", bad, wr_addr[0], wr_data[0]);
    end
    checks++;
    if (wr_cyc.size() != P || grant_cyc.size() != 1 || wr_cyc[0] != grant_cyc[0] + 1 || done_cyc.size() != 1 || done_cyc[0] != wr_cyc[P-1] + 1) begin
      errors++;
      $display("FAIL single_timing: first write lag or done timing wrong (writes %0d)", wr_cyc.size());
    end
    checks++;
    if (aborts.size() != 0) begin
      errors++;
      $display("FAIL single_no_abort: got %0d aborts expected 0", aborts.size());
    end
  endtask

  task automatic test_round_robin();
    int exp_order[4] = '{0, 3, 63, 0};
    do_reset();
    ready_for_read[0] = 1; run_enable[0] = 1;
    ready_for_read[3] = 1; run_enable[3] = 1;
    ready_for_read[63] = 1; run_enable[63] = 1;
    sched_enable = 1;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 150 && dones.size() <= p; i++) tick();
      repeat (2) tick();
      host_release = 1;
      tick();
      host_release = 0;
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (p >= grants.size() || grants[p] != exp_order[p] || p >= dones.size() || dones[p] != exp_order[p]) begin
        errors++;
        $display("FAIL rr_order[%0d]: grant %0d done %0d expected %0d", p,
                 p < grants.size() ? grants[p] : -1, p < dones.size() ? dones[p] : -1, exp_order[p]);
      end
    end
  endtask

  task automatic test_buffer_hold();
    do_reset();
    ready_for_read[2:1] = 2'b11;
    run_enable[2:1] = 2'b11;
    sched_enable = 1;
    for (int i = 0; i < 10 && grants.size() < 1; i++) tick();
    repeat (5) tick();
    host_release = 1;
    tick();
    host_release = 0;
    for (int i = 0; i < 120 && dones.size() < 1; i++) tick();
    repeat (200) tick();
    checks++;
    if (grants.size() != 1 || grants[0] != 1 || runs.size() != 1 || runs[0] != P) begin
      errors++;
      $display("FAIL hold_no_pump: grants %0d runs %0d expected single slot 1 copy of %0d", grants.size(), runs.size(), P);
    end
    checks++;
    if (buf_busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_busy: got %b expected 1", buf_busy);
    end
    host_release = 1;
    tick();
    host_release = 0;
    checks++;
    if (buf_busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: busy got %b expected 0", buf_busy);
    end
    repeat (5) tick();
    checks++;
    if (grants.size() != 2 || grants[1] != 2) begin
      errors++;
      $display("FAIL hold_next_grant: got %0d grants last %0d expected slot 2", grants.size(), grants.size() ? grants[grants.size()-1] : -1);
    end
  endtask

  task automatic test_abort();
    int bad;
    do_reset();
    ready_for_read[8:7] = 2'b11;
    run_enable[8:7] = 2'b11;
    sched_enable = 1;
    for (int i = 0; i < 10 && grants.size() < 1; i++) tick();
    repeat (10) tick();
    ready_for_read[7] = 0;
    for (int i = 0; i < 20 && aborts.size() < 1; i++) tick();
    ready_for_read[7] = 1;
    checks++;
    if (aborts.size() != 1 || aborts[0] != 7 || dones.size() != 0) begin
      errors++;
      $display("FAIL abort_pulse: aborts %0d slot %0d dones %0d expected 1 abort of slot 7", aborts.size(), aborts.size() ? aborts[0] : -1, dones.size());
    end
    checks++;
    if (buf_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b expected 0", buf_busy);
    end
    checks++;
    if (wr_addr.size() > 11 || wr_addr.size() < 1 || runs.size() != 1 || runs[0] > 11) begin
      errors++;
      $display("FAIL abort_limit: writes %0d pump run %0d expected at most 11", wr_addr.size(), runs.size() ? runs[0] : -1);
    end
    bad = 0;
    for (int k = 0; k < wr_addr.size(); k++)
      if (wr_addr[k] !== 8'(k) || wr_data[k] !== base(7) + W'(k)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_wr_content: %0d bad writes", bad);
    end
    for (int i = 0; i < 10 && grants.size() < 2; i++) tick();
    checks++;
    if (grants.size() != 2 || grants[1] != 8) begin
      errors++;
      $display("FAIL abort_next_grant: got %0d grants last %0d expected slot 8", grants.size(), grants.size() ? grants[grants.size()-1] : -1);
    end
  endtask

  task automatic test_mask_enable();
    do_reset();
    ready_for_read[4] = 1;
    ready_for_read[6] = 1;
    run_enable[6] = 1;
    repeat (30) tick();
    checks++;
    if (grants.size() != 0) begin
      errors++;
      $display("FAIL mask_sched_off: got %0d grants expected 0", grants.size());
    end
    sched_enable = 1;
    for (int i = 0; i < 5 && grants.size() < 1; i++) tick();
    checks++;
    if (grants.size() != 1 || grants[0] != 6) begin
      errors++;
      $display("FAIL mask_grant: got %0d grants first %0d expected slot 6", grants.size(), grants.size() ? grants[0] : -1);
    end
    repeat (3) tick();
    sched_enable = 0;
    for (int i = 0; i < 120 && dones.size() < 1; i++) tick();
    checks++;
    if (dones.size() != 1 || dones[0] != 6 || runs.size() != 1 || runs[0] != P) begin
      errors++;
      $display("FAIL mask_copy_kept: dones %0d runs %0d expected full copy of slot 6", dones.size(), runs.size());
    end
    ready_for_read[6] = 0;
    sched_enable = 1;
    host_release = 1;
    tick();
    host_release = 0;
    repeat (30) tick();
    checks++;
    if (grants.size() != 1) begin
      errors++;
      $display("FAIL mask_slot4: got %0d grants expected 1 (slot 4 masked)", grants.size());
    end
  endtask

  task automatic test_reset_mid_copy();
    do_reset();
    ready_for_read[0] = 1; run_enable[0] = 1;
    ready_for_read[9] = 1; run_enable[9] = 1;
    sched_enable = 1;
    for (int i = 0; i < 10 && grants.size() < 1; i++) tick();
    repeat (19) tick();
    rst_n = 0;
    #1;
    checks++;
    if ({pump_enable, buf_wren, buf_addr, buf_wdata, pkt_done, pkt_abort, done_slot, buf_busy} !== '0) begin
      errors++;
      $display("FAIL midreset_zero: got %h expected 0", {pump_enable, buf_wren, buf_addr, buf_wdata, pkt_done, pkt_abort, done_slot, buf_busy});
    end
    repeat (2) tick();
    rst_n = 1;
    for (int i = 0; i < 10 && grants.size() < 2; i++) tick();
    checks++;
    if (grants.size() != 2 || grants[1] != 0) begin
      errors++;
      $display("FAIL midreset_first_grant: got %0d grants last %0d expected slot 0", grants.size(), grants.size() ? grants[grants.size()-1] : -1);
    end
    checks++;
    if (dones.size() != 0 || aborts.size() != 0) begin
      errors++;
      $display("FAIL midreset_no_pulse: dones %0d aborts %0d expected 0", dones.size(), aborts.size());
    end
  endtask

  task automatic test_random();
    int s, exp_slot, wstart, bad;
    logic [N-1:0] elig;
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      rr_last = N - 1;
      ready_for_read = {$urandom, $urandom};
      run_enable = {$urandom, $urandom};
      s = $urandom_range(0, N - 1);
      ready_for_read[s] = 1;
      run_enable[s] = 1;
      elig = ready_for_read & run_enable;
      sched_enable = 1;
      for (int pk = 0; pk < 3; pk++) begin
        exp_slot = rr_next(elig, rr_last);
        wstart = wr_addr.size();
        for (int i = 0; i < 150 && dones.size() <= pk; i++) tick();
        checks++;
        if (dones.size() != pk + 1 || dones[pk] != exp_slot || grants.size() != pk + 1 || grants[pk] != exp_slot) begin
          errors++;
          $display("FAIL rand_grant[%0d.%0d]: done %0d grant %0d expected %0d", ph, pk,
                   dones.size() > pk ? dones[pk] : -1, grants.size() > pk ? grants[pk] : -1, exp_slot);
        end
        bad = (wr_addr.size() - wstart == P) ? 0 : 1;
        for (int k = 0; k < P && wstart + k < wr_addr.size(); k++)
          if (wr_addr[wstart+k] !== 8'(k) || wr_data[wstart+k] !== base(exp_slot) + W'(k)) bad++;
        checks++;
        if (bad != 0) begin
          errors++;
          $display("FAIL rand_writes[%0d.%0d]: %0d problems, %0d writes expected %0d", ph, pk, bad, wr_addr.size() - wstart, P);
        end
        rr_last = exp_slot;
        repeat ($urandom_range(1, 5)) tick();
        host_release = 1;
        tick();
        host_release = 0;
      end
    end
    checks++;
    if (bad_onehot || bad_both) begin
      errors++;
      $display("FAIL global_flags: onehot violation %0b done+abort overlap %0b expected 0 0", bad_onehot, bad_both);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_single_copy();
    test_round_robin();
    test_buffer_hold();
    test_abort();
    test_mask_enable();
    test_reset_mid_copy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
